// File: rtl/fixed_p_std_mult_shared_if.sv
// rtl/fixed_p_std_mult_shared_if.sv - requester-side bus of the shared fixed-point multiplier
interface fixed_p_std_mult_shared_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]       go;
    logic [NUM_REQ*WIDTH-1:0] left;
    logic [NUM_REQ*WIDTH-1:0] right;
    logic [WIDTH-1:0]         out;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic                     overflow;

    modport master (output go, left, right, input out, done, busy, overflow);
    modport slave  (input go, left, right, output out, done, busy, overflow);
endinterface

// File: rtl/fixed_p_std_mult_shared.sv
// rtl/fixed_p_std_mult_shared.sv - round-robin shared unsigned fixed-point multiplier with go/done per requester
// Optional saturation on integer overflow: define FIXED_P_STD_MULT_SHARED_SAT_EN.
module fixed_p_std_mult_shared #(
    parameter int WIDTH       = 32,
    parameter int INT_WIDTH   = 8,
    parameter int FRACT_WIDTH = 24,
    parameter int NUM_REQ     = 2,
    parameter int LATENCY     = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    fixed_p_std_mult_shared_if.slave   bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]        grant_q, grant_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     opl_q, opl_d;
    logic [WIDTH-1:0]     opr_q, opr_d;
    logic [WIDTH-1:0]     out_q, out_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 ovf_q, ovf_d;

    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     result;
    logic                 result_ovf;
    logic [IW-1:0]        pick;
    logic                 found;
    int                   idx;
    logic                 unused_bits;

    assign product = {{WIDTH{1'b0}}, opl_q} * {{WIDTH{1'b0}}, opr_q};
    assign unused_bits = ^{product[FRACT_WIDTH-1:0], product[2*WIDTH-1:WIDTH+FRACT_WIDTH]};

`ifdef FIXED_P_STD_MULT_SHARED_SAT_EN
    always_comb begin
        result     = product[WIDTH+FRACT_WIDTH-1:FRACT_WIDTH];
        result_ovf = 1'b0;
        if (|product[2*WIDTH-1:WIDTH+FRACT_WIDTH]) begin
            result     = '1;
            result_ovf = 1'b1;
        end
    end
`else
    always_comb begin
        result     = product[WIDTH+FRACT_WIDTH-1:FRACT_WIDTH];
        result_ovf = 1'b0;
    end
`endif

    // First pending requester at or after rr_ptr, wrapping around.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && bus.go[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        opl_d    = opl_q;
        opr_d    = opr_q;
        out_d    = out_q;
        done_d   = '0;
        busy_d   = busy_q;
        ovf_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    opl_d    = bus.left[int'(pick)*WIDTH +: WIDTH];
                    opr_d    = bus.right[int'(pick)*WIDTH +: WIDTH];
                    grant_d  = pick;
                    cnt_d    = '0;
                    rr_ptr_d = IW'((int'(pick) + 1) % NUM_REQ);
                    busy_d   = 1'b1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(LATENCY - 1)) begin
                    out_d           = result;
                    ovf_d           = result_ovf;
                    done_d[grant_q] = 1'b1;
                    state_d         = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            opl_q    <= '0;
            opr_q    <= '0;
            out_q    <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            opl_q    <= opl_d;
            opr_q    <= opr_d;
            out_q    <= out_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.out      = out_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_fixed_p_std_mult_shared.sv
// tb/tb_fixed_p_std_mult_shared.sv - scoreboard bench for the shared fixed-point multiplier
module tb_fixed_p_std_mult_shared;
    localparam int W = 32;

    typedef struct {
        int         idx;
        logic [W-1:0] res;
        logic       ovf;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   t0;
    int   nd;
    int   n;
    exp_t exp_q[$];
    exp_t mon_e;
    exp_t push_e;

    fixed_p_std_mult_shared_if #(.WIDTH(W), .NUM_REQ(2)) bus ();

    fixed_p_std_mult_shared #(
        .WIDTH(W), .INT_WIDTH(8), .FRACT_WIDTH(24), .NUM_REQ(2), .LATENCY(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_done(input int idx, input logic [W-1:0] res, input logic ovf, input int c);
        push_e.idx = idx;
        push_e.res = res;
        push_e.ovf = ovf;
        push_e.cyc = c;
        exp_q.push_back(push_e);
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] l, input logic [W-1:0] r);
        bus.left[i*W +: W]  = l;
        bus.right[i*W +: W] = r;
    endtask

    // Requesters release go when their done is seen; bounded wait for idle.
    task automatic drain(input int maxc);
        int k;
        k = 0;
        while ((bus.go != 0 || bus.busy) && k < maxc) begin
            @(negedge clk);
            k++;
            bus.go = bus.go & ~bus.done;
        end
        check("drain_bound", 64'(k < maxc), 64'd1);
    endtask

    always @(negedge clk) begin
        if (bus.done != 0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=%b required=none", bus.done);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_vec", 64'(bus.done), 64'(2'b01 << mon_e.idx));
                check("out", 64'(bus.out), 64'(mon_e.res));
                check("overflow", 64'(bus.overflow), 64'(mon_e.ovf));
                check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.go = '0;
        bus.left = '0;
        bus.right = '0;
        repeat (3) @(negedge clk);
        check("rst_out", 64'(bus.out), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_ovf", 64'(bus.overflow), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1.5 * 2.0 with busy profile
        set_ops(0, 32'h0180_0000, 32'h0200_0000);
        bus.go[0] = 1'b1;
        t0 = cyc;
        expect_done(0, 32'h0300_0000, 1'b0, t0 + 4);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("busy_c%0d", k), 64'(bus.busy), 64'((k <= 4) ? 1 : 0));
            bus.go = bus.go & ~bus.done;
        end

        // 0.5 * 0.5, operands disturbed after grant
        set_ops(0, 32'h0080_0000, 32'h0080_0000);
        bus.go[0] = 1'b1;
        t0 = cyc;
        expect_done(0, 32'h0040_0000, 1'b0, t0 + 4);
        @(negedge clk);
        set_ops(0, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
        drain(20);
        @(negedge clk);

        // 16.0 * 16.0 exceeds the integer range
        set_ops(0, 32'h1000_0000, 32'h1000_0000);
        bus.go[0] = 1'b1;
        t0 = cyc;
`ifdef FIXED_P_STD_MULT_SHARED_SAT_EN
        expect_done(0, 32'hFFFF_FFFF, 1'b1, t0 + 4);
`else
        expect_done(0, 32'h0000_0000, 1'b0, t0 + 4);
`endif
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus.go = bus.go & ~bus.done;
        end
        check("ovf_after_done", 64'(bus.overflow), 64'd0);
`ifdef FIXED_P_STD_MULT_SHARED_SAT_EN
        check("ovf_out_hold", 64'(bus.out), 64'hFFFF_FFFF);
`else
        check("ovf_out_hold", 64'(bus.out), 64'h0);
`endif

        // requester 1 drops go right after grant: 0.75 * 2.0
        set_ops(1, 32'h00C0_0000, 32'h0200_0000);
        bus.go[1] = 1'b1;
        t0 = cyc;
        expect_done(1, 32'h0180_0000, 1'b0, t0 + 4);
        @(negedge clk);
        bus.go[1] = 1'b0;
        for (int k = 2; k <= 7; k++) begin
            @(negedge clk);
            check($sformatf("drop_busy_c%0d", k), 64'(bus.busy), 64'((k <= 4) ? 1 : 0));
        end

        // reset in the middle of an operation
        set_ops(0, 32'h0180_0000, 32'h0200_0000);
        bus.go[0] = 1'b1;
        @(negedge clk);
        bus.go[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_out", 64'(bus.out), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        // contention after reset: rr_ptr back at 0, grants alternate 0,1,0,1
        set_ops(0, 32'h0180_0000, 32'h0200_0000);
        set_ops(1, 32'h0080_0000, 32'h0080_0000);
        bus.go = 2'b11;
        t0 = cyc;
        expect_done(0, 32'h0300_0000, 1'b0, t0 + 4);
        expect_done(1, 32'h0040_0000, 1'b0, t0 + 9);
        expect_done(0, 32'h0300_0000, 1'b0, t0 + 14);
        expect_done(1, 32'h0040_0000, 1'b0, t0 + 19);
        nd = 0;
        n = 0;
        while (n < 40 && (bus.go != 0 || bus.busy)) begin
            @(negedge clk);
            n++;
            if (bus.done != 0) nd++;
            if (nd == 4) bus.go = '0;
        end
        check("contention_bound", 64'(n < 40), 64'd1);

        repeat (8) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
